// File: rtl/inter_pkg.sv
// Shared types and field positions for the three-master round-robin scheduler.
package inter_pkg;

  localparam int NUM_MASTERS = 3;

  // Request word layout: [6] slave select, [5:3] address, [2:0] value.
  localparam int SLV_BIT  = 6;
  localparam int ADDR_MSB = 5;
  localparam int ADDR_LSB = 3;
  localparam int VAL_MSB  = 2;
  localparam int VAL_LSB  = 0;

  typedef logic [6:0] req_t;

  // Master identifier: 0 = none, 1..3 = master number.
  typedef logic [1:0] mid_t;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  // Next master in rotating order, wrapping 3 -> 1.
  function automatic mid_t next_master(input mid_t m);
    return (m == 2'd3) ? 2'd1 : m + 2'd1;
  endfunction

endpackage

// File: rtl/inter_req_fifo.sv
// Small per-master request FIFO. DEPTH must be a power of two so the
// read/write pointers wrap modulo DEPTH by natural overflow.
module inter_req_fifo
  import inter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  req_t                     push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output req_t                     head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Next pointer and occupancy; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write on push.
  // NOTE: the storage array has no reset; an entry is only ever read after it was written, and count/pointers carry validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inter_rr_sched.sv
// Round-robin scheduler: three buffered masters share one registered
// valid/ready issue path to two slaves. One request is in flight at a time.
module inter_rr_sched
  import inter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_1,
  input  logic       in_valid_2,
  input  logic       in_valid_3,
  input  logic [6:0] data_in_1,
  input  logic [6:0] data_in_2,
  input  logic [6:0] data_in_3,
  output logic       in_ready_1,
  output logic       in_ready_2,
  output logic       in_ready_3,
  input  logic       ready_slave1,
  input  logic       ready_slave2,
  output logic       valid_slave1,
  output logic       valid_slave2,
  output logic [2:0] addr_out,
  output logic [2:0] value_out,
  output logic       handshake_slave1,
  output logic       handshake_slave2,
  output logic [1:0] grant_id
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_MASTERS-1:0] in_valid, in_ready, push, pop, full, empty;
  req_t                   data_in [NUM_MASTERS];
  req_t                   head    [NUM_MASTERS];
  logic [CW-1:0]          cnt     [NUM_MASTERS];

  assign in_valid   = {in_valid_3, in_valid_2, in_valid_1};
  assign data_in[0] = data_in_1;
  assign data_in[1] = data_in_2;
  assign data_in[2] = data_in_3;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_fifo
    assign in_ready[i] = (cnt[i] != CW'(DEPTH));
    assign push[i]     = in_valid[i] & ~full[i];

    inter_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_data (data_in[i]),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (head[i]),
      .count     (cnt[i])
    );
  end

  assign in_ready_1 = in_ready[0];
  assign in_ready_2 = in_ready[1];
  assign in_ready_3 = in_ready[2];

  // First non-empty master scanning ptr, ptr+1, ptr+2 (wrapping 3 -> 1); 0 if none.
  function automatic mid_t rr_pick(input mid_t ptr, input logic [NUM_MASTERS-1:0] nonempty);
    mid_t m;
    mid_t pick;
    m    = ptr;
    pick = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (pick == '0 && nonempty[m - 2'd1]) pick = m;
      m = next_master(m);
    end
    return pick;
  endfunction

  state_t     state_q, state_d;
  mid_t       rr_q, rr_d;
  mid_t       gnt_q, gnt_d;
  logic       valid1_q, valid1_d, valid2_q, valid2_d;
  logic       hs1_q, hs1_d, hs2_q, hs2_d;
  logic [2:0] addr_q, addr_d, value_q, value_d;
  mid_t       pick;
  req_t       pick_head;
  logic       accept;

  assign pick   = rr_pick(rr_q, ~empty);
  assign accept = (valid1_q & ready_slave1) | (valid2_q & ready_slave2);

  // Arbitrate in IDLE using registered FIFO state; hold and wait for acceptance in ISSUE.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    valid1_d  = valid1_q;
    valid2_d  = valid2_q;
    addr_d    = addr_q;
    value_d   = value_q;
    hs1_d     = hs1_q;
    hs2_d     = hs2_q;
    pop       = '0;
    pick_head = '0;
    case (state_q)
      S_IDLE: begin
        hs1_d = 1'b0;
        hs2_d = 1'b0;
        if (pick != '0) begin
          pick_head = head[pick - 2'd1];
          valid1_d  = ~pick_head[SLV_BIT];
          valid2_d  =  pick_head[SLV_BIT];
          addr_d    = pick_head[ADDR_MSB:ADDR_LSB];
          value_d   = pick_head[VAL_MSB:VAL_LSB];
          gnt_d     = pick;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          pop[gnt_q - 2'd1] = 1'b1;
          hs1_d    = valid1_q;
          hs2_d    = valid2_q;
          valid1_d = 1'b0;
          valid2_d = 1'b0;
          addr_d   = '0;
          value_d  = '0;
          gnt_d    = '0;
          rr_d     = next_master(gnt_q);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_q     <= 2'd1;
      gnt_q    <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      addr_q   <= '0;
      value_q  <= '0;
      hs1_q    <= 1'b0;
      hs2_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
      addr_q   <= addr_d;
      value_q  <= value_d;
      hs1_q    <= hs1_d;
      hs2_q    <= hs2_d;
    end
  end

  assign valid_slave1     = valid1_q;
  assign valid_slave2     = valid2_q;
  assign addr_out         = addr_q;
  assign value_out        = value_q;
  assign handshake_slave1 = hs1_q;
  assign handshake_slave2 = hs2_q;
  assign grant_id         = gnt_q;

endmodule

// File: tb/tb_inter_rr_sched.sv
// Self-checking bench for inter_rr_sched: directed scenarios followed by a
// randomized run, all compared every cycle against a transaction-level model.
module tb_inter_rr_sched;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       in_valid_1, in_valid_2, in_valid_3;
  logic [6:0] data_in_1, data_in_2, data_in_3;
  logic       in_ready_1, in_ready_2, in_ready_3;
  logic       ready_slave1, ready_slave2;
  logic       valid_slave1, valid_slave2;
  logic [2:0] addr_out, value_out;
  logic       handshake_slave1, handshake_slave2;
  logic [1:0] grant_id;

  inter_rr_sched #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_1       (in_valid_1),
    .in_valid_2       (in_valid_2),
    .in_valid_3       (in_valid_3),
    .data_in_1        (data_in_1),
    .data_in_2        (data_in_2),
    .data_in_3        (data_in_3),
    .in_ready_1       (in_ready_1),
    .in_ready_2       (in_ready_2),
    .in_ready_3       (in_ready_3),
    .ready_slave1     (ready_slave1),
    .ready_slave2     (ready_slave2),
    .valid_slave1     (valid_slave1),
    .valid_slave2     (valid_slave2),
    .addr_out         (addr_out),
    .value_out        (value_out),
    .handshake_slave1 (handshake_slave1),
    .handshake_slave2 (handshake_slave2),
    .grant_id         (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: per-master queues, one in-flight transfer, rotating start pointer.
  logic [6:0] mq [3][$];
  bit         m_busy;
  int         m_gnt;
  logic [6:0] m_word;
  bit         m_hs1, m_hs2;
  int         m_rr;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    m_busy = 0; m_gnt = 0; m_word = '0; m_hs1 = 0; m_hs2 = 0; m_rr = 1;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit         iv [3];
    logic [6:0] din [3];
    bit         can_push [3];
    bit         slv, found;
    int         idx;
    iv  = '{in_valid_1, in_valid_2, in_valid_3};
    din = '{data_in_1, data_in_2, data_in_3};
    for (int i = 0; i < 3; i++) can_push[i] = (mq[i].size() < DEPTH);
    if (m_busy) begin
      slv = m_word[6];
      if ((!slv && ready_slave1) || (slv && ready_slave2)) begin
        mq[m_gnt-1].delete(0);
        m_busy = 0;
        m_hs1  = !slv;
        m_hs2  = slv;
        m_rr   = (m_gnt % 3) + 1;
      end
    end else begin
      m_hs1 = 0;
      m_hs2 = 0;
      found = 0;
      for (int k = 0; k < 3; k++) begin
        idx = (m_rr - 1 + k) % 3;
        if (!found && mq[idx].size() > 0) begin
          found  = 1;
          m_busy = 1;
          m_gnt  = idx + 1;
          m_word = mq[idx][0];
        end
      end
    end
    for (int i = 0; i < 3; i++)
      if (iv[i] && can_push[i]) mq[i].push_back(din[i]);
  endtask

  task automatic compare_all();
    check("valid_slave1", valid_slave1, m_busy && !m_word[6]);
    check("valid_slave2", valid_slave2, m_busy && m_word[6]);
    check("addr_out",     addr_out,  m_busy ? m_word[5:3] : 3'd0);
    check("value_out",    value_out, m_busy ? m_word[2:0] : 3'd0);
    check("grant_id",     grant_id,  m_busy ? m_gnt : 0);
    check("hs_slave1",    handshake_slave1, m_hs1);
    check("hs_slave2",    handshake_slave2, m_hs2);
    check("in_ready_1",   in_ready_1, mq[0].size() < DEPTH);
    check("in_ready_2",   in_ready_2, mq[1].size() < DEPTH);
    check("in_ready_3",   in_ready_3, mq[2].size() < DEPTH);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic clear_inputs();
    in_valid_1 = 0; in_valid_2 = 0; in_valid_3 = 0;
    data_in_1 = '0; data_in_2 = '0; data_in_3 = '0;
    ready_slave1 = 0; ready_slave2 = 0;
  endtask

  // Asynchronous reset applied between edges; released on a falling edge.
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  int   gq [$];
  bit   prev_v, v;
  int   low_run;
  int   hs_count;

  task automatic observe_fair();
    v = valid_slave1 | valid_slave2;
    if (v && !prev_v) begin
      if (gq.size() > 0) check("fair_gap", low_run, 1);
      gq.push_back(int'(grant_id));
      low_run = 0;
    end
    if (!v) low_run++;
    prev_v = v;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1;

    // Single request to slave 2 from master 2.
    in_valid_2 = 1; data_in_2 = 7'b1_101_011;
    tick();
    in_valid_2 = 0;
    tick();
    check("single_valid2", valid_slave2, 1);
    check("single_addr",   addr_out, 5);
    check("single_value",  value_out, 3);
    check("single_grant",  grant_id, 2);
    ready_slave2 = 1;
    tick();
    check("single_hs2", handshake_slave2, 1);
    ready_slave2 = 0;
    tick();
    check("single_hs2_off", handshake_slave2, 0);
    check("single_idle_grant", grant_id, 0);

    // Fairness: fill every FIFO, then accept everything.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      in_valid_1 = 1; in_valid_2 = 1; in_valid_3 = 1;
      data_in_1 = 7'($urandom); data_in_2 = 7'($urandom); data_in_3 = 7'($urandom);
      tick();
    end
    clear_inputs();
    ready_slave1 = 1; ready_slave2 = 1;
    gq.delete(); prev_v = 0; low_run = 0;
    observe_fair();
    for (int c = 0; c < 20; c++) begin
      tick();
      observe_fair();
    end
    check("fair_count", gq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) check("fair_grant", gq[i], (i % 3) + 1);

    // Backpressure on master 1 with slave 1 stalled.
    do_reset();
    in_valid_1 = 1; data_in_1 = 7'b0_001_001;
    tick();
    data_in_1 = 7'b0_010_010;
    tick();
    check("bp_in_ready_1", in_ready_1, 0);
    data_in_1 = 7'b0_011_011;
    tick();
    in_valid_1 = 0;
    ready_slave1 = 1;
    hs_count = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (handshake_slave1) hs_count++;
    end
    check("bp_hs1_pulses", hs_count, 2);

    // Stall hold on slave 1 while slave 2 ready toggles.
    do_reset();
    in_valid_1 = 1; data_in_1 = 7'b0_110_101;
    tick();
    in_valid_1 = 0;
    tick();
    for (int c = 0; c < 10; c++) begin
      ready_slave2 = ~ready_slave2;
      tick();
      check("stall_valid1", valid_slave1, 1);
      check("stall_addr",   addr_out, 6);
      check("stall_value",  value_out, 5);
      check("stall_no_hs2", handshake_slave2, 0);
    end
    ready_slave2 = 0; ready_slave1 = 1;
    tick();
    check("stall_hs1", handshake_slave1, 1);
    ready_slave1 = 0;
    tick();

    // Push into master 3 on the same edge its head is accepted.
    do_reset();
    in_valid_3 = 1; data_in_3 = 7'b0_011_100;
    tick();
    in_valid_3 = 0;
    tick();
    check("cpp_grant", grant_id, 3);
    ready_slave1 = 1;
    in_valid_3 = 1; data_in_3 = 7'b1_010_001;
    tick();
    in_valid_3 = 0; ready_slave1 = 0;
    check("cpp_hs1", handshake_slave1, 1);
    check("cpp_in_ready_3", in_ready_3, 1);
    tick();
    check("cpp_valid2", valid_slave2, 1);
    check("cpp_addr",   addr_out, 2);
    check("cpp_value",  value_out, 1);
    check("cpp_grant2", grant_id, 3);
    ready_slave2 = 1;
    tick();
    check("cpp_hs2", handshake_slave2, 1);
    ready_slave2 = 0;
    tick();

    // Reset while a slave-2 transfer is pending.
    do_reset();
    in_valid_2 = 1; data_in_2 = 7'b1_111_010;
    in_valid_1 = 1; data_in_1 = 7'b0_100_100;
    tick();
    in_valid_2 = 0; in_valid_1 = 0;
    tick();
    check("rst_pre_valid2", valid_slave2, 0);
    check("rst_pre_valid1", valid_slave1, 1);
    ready_slave1 = 1;
    tick();
    ready_slave1 = 0;
    tick();
    check("rst_pre_valid2b", valid_slave2, 1);
    #2;
    do_reset();
    check("rst_async_valid2", valid_slave2, 0);
    for (int c = 0; c < 5; c++) begin
      ready_slave2 = 1;
      tick();
      check("rst_no_stale", valid_slave2, 0);
    end

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid_1 = 1'($urandom); in_valid_2 = 1'($urandom); in_valid_3 = 1'($urandom);
      data_in_1 = 7'($urandom); data_in_2 = 7'($urandom); data_in_3 = 7'($urandom);
      ready_slave1 = ($urandom_range(0, 3) != 0);
      ready_slave2 = ($urandom_range(0, 3) == 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inter_rr_sched.md
# inter_rr_sched

Round-robin request scheduler for the three-master / two-slave register interconnect. Each master pushes 7-bit requests into its own small FIFO. The scheduler grants one buffered request at a time in rotating order and drives it to the slave selected by bit 6, using a registered valid/ready handshake. It replaces fixed master-1-first priority so that a streaming master cannot starve the others, and it lets masters queue requests while a slave stalls.

## Interface
- DEPTH, 2, per-master FIFO depth; power of two, >= 2
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid_1/2/3  in  1  master request strobe; pushes when in_ready_x is high
- data_in_1/2/3  in  7  request word: [6] slave select (0 = slave1, 1 = slave2), [5:3] addr, [2:0] value
- in_ready_1/2/3  out  1  FIFO x not full; combinational from registered count
- ready_slave1/2  in  1  slave accepts the current transfer
- valid_slave1/2  out  1  registered; transfer pending to that slave
- addr_out  out  3  registered; address of the granted request
- value_out  out  3  registered; value of the granted request
- handshake_slave1/2  out  1  registered one-cycle pulse, asserted the cycle after acceptance
- grant_id  out  2  registered; 0 when idle, 1–3 = master currently granted

## Operation
- Reset (async): all FIFOs empty, rr_ptr = 1, state IDLE. All outputs are 0; in_ready_x = 1.
- Push: at a rising edge with in_valid_x && in_ready_x, data_in_x is written to FIFO x. A push while full cannot occur because in_ready_x = 0 when full; in_valid_x is ignored in that case.
- Round-robin search: start at rr_ptr and scan the order rr_ptr, rr_ptr+1, rr_ptr+2, with each step wrapping 3→1. Pick the first non-empty FIFO.
- State IDLE:
  - If any FIFO is non-empty, register the granted master's head entry:
    - valid_slave1 = ~head[6]; valid_slave2 = head[6]
    - addr_out = head[5:3]; value_out = head[2:0]
    - grant_id = granted master
    - next state ISSUE
  - handshake_slave1/2 <= 0.
  - If all FIFOs are empty, stay in IDLE with valid, addr, value and grant_id at 0.
- State ISSUE:
  - Hold valid, addr, value and grant_id stable.
  - Acceptance is valid_slaveN && ready_slaveN at a rising edge. On acceptance:
    - pop the granted FIFO
    - valid_slave1/2, addr_out, value_out, grant_id <= 0
    - handshake_slaveN <= 1
    - rr_ptr <= grant+1, wrapping 3→1
    - next state IDLE
  - ready from the non-selected slave is ignored.
  - There is no timeout; ISSUE waits indefinitely.
- Push and pop on the same FIFO at the same edge: both take effect and the count is unchanged. A push into the granted FIFO never alters the entry being driven.
- A request arriving into an empty FIFO while in IDLE is granted no earlier than the following edge. The arbitration compare uses registered FIFO state, not in_valid.

## Timing
- Request latency: a push at edge E0 into an idle, empty system gives arbitration at E1. valid/addr/value are high from E1 to the acceptance edge.
- Handshake: acceptance at edge Ea → handshake_slaveN high for exactly one cycle, Ea to Ea+1.
- Back-to-back: the next grant is registered at Ea+1, so valid is low for exactly one cycle (the handshake cycle) between consecutive transfers.
- Fairness: with all three FIFOs continuously non-empty, grants go 1,2,3,1,… Each master waits at most two other transfers.
- Reset asserted mid-transfer: outputs go to 0 immediately and queued requests are discarded.

## Structure
- Package inter_pkg holds:
  - state enum {S_IDLE, S_ISSUE}
  - NUM_MASTERS = 3
  - field positions SLV_BIT = 6, ADDR_MSB = 5, ADDR_LSB = 3, VAL_MSB = 2, VAL_LSB = 0
  - typedef req_t (7 bits)
- Sub-module inter_req_fifo (parameter DEPTH, req_t data) is instantiated three times. Its interface: push, pop, full, empty, head, and count with log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- The round-robin pick function lives in the top module.

## Test plan
- Single request: after reset, push data_in_2 = 7'b1_101_011 → at E1 valid_slave2 = 1, addr_out = 5, value_out = 3, grant_id = 2. Raise ready_slave2 → next cycle handshake_slave2 = 1 for one cycle, then all outputs 0.
- Fairness: fill all FIFOs, then hold ready_slave1 = ready_slave2 = 1 → grant_id sequence 1,2,3,1,2,3. valid is low exactly one cycle between grants.
- Backpressure: with DEPTH = 2 and ready_slave1 = 0, push 3 requests to master 1 → in_ready_1 falls after the second push and the third is ignored. Release ready → exactly 2 handshake_slave1 pulses.
- Stall hold: ready_slave1 = 0 for 10 cycles with a grant to slave1 → addr, value and valid are unchanged. A toggling ready_slave2 causes no handshake.
- Concurrent push/pop: push to master 3 on the same edge its head is accepted → count is unchanged and the new entry is issued later with the correct fields.
- Reset mid-ISSUE: assert rst_n low while valid_slave2 = 1 → all outputs 0 asynchronously. After release, no stale transfer appears.
